// File: rtl/ram_bist_ctrl.sv
// March-style BIST initiator for the dual-port RAM.
// Optional RAM_BIST_ADDR_DATA_EN: address-dependent background data.
module ram_bist_ctrl #(
  parameter int               ADDR_W = 8,
  parameter int               DATA_W = 4,
  parameter int               DEPTH  = 256,
  parameter logic [DATA_W-1:0] PAT   = 4'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        err_cnt
);

`ifdef RAM_BIST_ADDR_DATA_EN
  localparam logic ADDR_MIX = 1'b1;
`else
  localparam logic ADDR_MIX = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WR_BKG,
    RD_BKG,
    WR_INV,
    RD_INV,
    DRAIN,
    DONE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                re_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic [DATA_W-1:0]   rexp_q;

  logic                cmp_vld_q;
  logic [DATA_W-1:0]   cmp_exp_q;
  logic [ADDR_W-1:0]   cmp_addr_q;

  logic [7:0]          err_q, err_d;
  logic [ADDR_W-1:0]   fail_q, fail_d;
  logic                seen_q, seen_d;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;

  logic                start_go;
  logic                miss;

  // Background value for an address; inverse phases use its complement.
  function automatic logic [DATA_W-1:0] bkg_f(input logic [ADDR_W-1:0] a);
    return PAT ^ (DATA_W'(a) & {DATA_W{ADDR_MIX}});
  endfunction

  assign start_go = start && (state_q == IDLE || state_q == DONE);

  // March sequencer: state, address counter and registered RAM port drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      raddr_q <= '0;
      rexp_q  <= '0;
    end else begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      raddr_q <= '0;
      rexp_q  <= '0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= WR_BKG;
            cnt_q   <= '0;
          end
        end
        WR_BKG: begin
          we_q    <= 1'b1;
          waddr_q <= cnt_q;
          wdata_q <= bkg_f(cnt_q);
          if (cnt_q == LAST) begin
            state_q <= RD_BKG;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        RD_BKG: begin
          re_q    <= 1'b1;
          raddr_q <= cnt_q;
          rexp_q  <= bkg_f(cnt_q);
          if (cnt_q == LAST) begin
            state_q <= WR_INV;
            cnt_q   <= LAST;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        WR_INV: begin
          we_q    <= 1'b1;
          waddr_q <= cnt_q;
          wdata_q <= ~bkg_f(cnt_q);
          if (cnt_q == '0) begin
            state_q <= RD_INV;
            cnt_q   <= LAST;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        RD_INV: begin
          re_q    <= 1'b1;
          raddr_q <= cnt_q;
          rexp_q  <= ~bkg_f(cnt_q);
          if (cnt_q == '0) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        DRAIN: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Compare pipeline: capture what the in-flight read should return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_vld_q  <= 1'b0;
      cmp_exp_q  <= '0;
      cmp_addr_q <= '0;
    end else begin
      cmp_vld_q  <= re_q;
      cmp_exp_q  <= rexp_q;
      cmp_addr_q <= raddr_q;
    end
  end

  // Mismatch detection, saturating error count and first-fail capture.
  always_comb begin
    miss   = cmp_vld_q && (read_data != cmp_exp_q);
    err_d  = err_q;
    fail_d = fail_q;
    seen_d = seen_q;
    if (miss) begin
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
      if (!seen_q) begin
        fail_d = cmp_addr_q;
      end
      seen_d = 1'b1;
    end
  end

  // Result and status registers; verdict lands once the last compare retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= '0;
      fail_q <= '0;
      seen_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (start_go) begin
      err_q  <= '0;
      fail_q <= '0;
      seen_q <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      fail_q <= fail_d;
      seen_q <= seen_d;
      if (state_q == DONE && busy_q) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        pass_q <= (err_d == 8'd0);
      end
    end
  end

  assign write_en   = we_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;
  assign read_en    = re_q;
  assign read_addr  = raddr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = fail_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural RAM and fault injection.
// Honours RAM_BIST_ADDR_DATA_EN in its expected-data model.
module tb_ram_bist_ctrl;

  localparam int AW = 8;
  localparam int DW = 4;
  localparam int D  = 256;
  localparam logic [DW-1:0] P = 4'hA;

  logic          clk;
  logic          rst;
  logic          start;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          read_en;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [7:0]    err_cnt;

  int n_tests;
  int n_fail;
  int fault_mode;
  int acc_idx;
  int seq_bad;
  int both_on;
  int cyc;

  logic [DW-1:0] mem [D];
  logic [DW-1:0] rd_q;

  ram_bist_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH (D),
    .PAT   (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .write_en  (write_en),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_en   (read_en),
    .read_addr (read_addr),
    .read_data (read_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with optional read faults.
  always @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
    if (read_en) begin
      if (fault_mode == 1 && read_addr == 8'h13)
        rd_q <= 4'hF;
      else if (fault_mode == 2 &&
               (read_addr == 8'h20 || read_addr == 8'h40))
        rd_q <= mem[read_addr] | 4'h1;
      else
        rd_q <= mem[read_addr];
    end
  end
  assign read_data = rd_q;

  function automatic logic [DW-1:0] bkg(input int a);
    logic [DW-1:0] v;
    v = P;
`ifdef RAM_BIST_ADDR_DATA_EN
    v = P ^ DW'(a);
`endif
    return v;
  endfunction

  // Access-order monitor: expected march order, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_en && read_en) begin
      both_on = both_on + 1;
    end else if (write_en || read_en) begin
      if (acc_idx >= 4 * D) begin
        seq_bad = seq_bad + 1;
      end else begin
        int ph;
        int k;
        int ea;
        logic wr;
        logic [DW-1:0] ed;
        ph = acc_idx / D;
        k  = acc_idx % D;
        ea = (ph < 2) ? k : (D - 1 - k);
        wr = (ph == 0 || ph == 2);
        ed = (ph == 0) ? bkg(ea) : ~bkg(ea);
        if (wr) begin
          if (!write_en || write_addr != AW'(ea) ||
              write_data != ed)
            seq_bad = seq_bad + 1;
        end else begin
          if (!read_en || read_addr != AW'(ea))
            seq_bad = seq_bad + 1;
        end
      end
      acc_idx = acc_idx + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start, optionally re-pulse mid-run, count edges until done.
  task automatic run_bist(input int repulse_at, output int n);
    @(negedge clk);
    acc_idx = 0;
    seq_bad = 0;
    both_on = 0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_done", 32'(done), 0);
    check("start_pass", 32'(pass), 0);
    check("start_err", 32'(err_cnt), 0);
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n = n + 1;
      start = (repulse_at != 0 && n == repulse_at);
    end
    start = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    fault_mode = 0;
    acc_idx    = 0;
    seq_bad    = 0;
    both_on    = 0;
    rst        = 1'b1;
    start      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_fail", 32'(fail_addr), 0);
    check("rst_we", 32'(write_en), 0);
    check("rst_re", 32'(read_en), 0);

    run_bist(0, cyc);
    check("r1_cyc", cyc, 4 * D + 2);
    check("r1_pass", 32'(pass), 1);
    check("r1_err", 32'(err_cnt), 0);
    check("r1_fail", 32'(fail_addr), 0);
    check("r1_acc", acc_idx, 4 * D);
    check("r1_seq", seq_bad, 0);
    check("r1_both", both_on, 0);
    repeat (5) @(negedge clk);
    check("r1_hold", 32'(done), 1);
    check("r1_idle", 32'(busy), 0);

    fault_mode = 1;
    run_bist(0, cyc);
    check("r2_cyc", cyc, 4 * D + 2);
    check("r2_err", 32'(err_cnt), 2);
    check("r2_fail", 32'(fail_addr), 32'h13);
    check("r2_pass", 32'(pass), 0);

    fault_mode = 2;
    run_bist(0, cyc);
    check("r3_err", 32'(err_cnt), 2);
    check("r3_fail", 32'(fail_addr), 32'h20);
    check("r3_pass", 32'(pass), 0);

    fault_mode = 0;
    run_bist(300, cyc);
    check("r4_cyc", cyc, 4 * D + 2);
    check("r4_pass", 32'(pass), 1);
    check("r4_acc", acc_idx, 4 * D);
    check("r4_seq", seq_bad, 0);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!(write_en && write_addr == 8'h80 && cyc > 600) &&
           cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
    end
    check("rst_hit", 32'(write_en && write_addr == 8'h80), 1);
    rst = 1'b1;
    #1;
    check("mid_we", 32'(write_en), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_idle_we", 32'(write_en || read_en), 0);

    run_bist(0, cyc);
    check("r5_cyc", cyc, 4 * D + 2);
    check("r5_pass", 32'(pass), 1);
    check("r5_acc", acc_idx, 4 * D);
    check("r5_seq", seq_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
